// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//   Classifies a debounced button level into click / double-click / long-press
//   events, with optional auto-repeat while the button stays held long.
//
//   Optional feature macro: BUTTON_REPEAT_EN
//     defined   -> o_repeat pulses every REPEAT_T ticks while in LONG
//     undefined -> o_repeat tied low, no repeat logic built
//
//   Parameters
//     TICK_DIV : clk cycles per timing tick (>=2)
//     LONG_T   : ticks held before a long press is reported (>=1)
//     DCLICK_T : ticks after release during which a new press is a double click
//     REPEAT_T : ticks between auto-repeat pulses (>=1)
//
//   Ports
//     i_clk        : system clock, all logic on rising edge
//     i_rst_n      : asynchronous active-low reset
//     i_btn        : debounced, clk-synchronous button level, 1 = pressed
//     o_click      : one-cycle pulse, single short press confirmed
//     o_dclick     : one-cycle pulse, double click
//     o_long_press : one-cycle pulse, hold reached LONG_T ticks
//     o_repeat     : one-cycle auto-repeat pulse while held long
//     o_busy       : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module button_event #(
  parameter int TICK_DIV = 1500,
  parameter int LONG_T   = 800,
  parameter int DCLICK_T = 250,
  parameter int REPEAT_T = 100
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_click,
  output logic o_dclick,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_busy
);

  localparam int MAX_LD = (LONG_T > DCLICK_T) ? LONG_T : DCLICK_T;
  localparam int MAX_T  = (MAX_LD > REPEAT_T) ? MAX_LD : REPEAT_T;
  localparam int TW     = $clog2(MAX_T + 1);
  localparam int PW     = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_btn_q;
  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_timer;
  logic          r_click;
  logic          r_dclick;
  logic          r_long;
  logic          r_busy;

  logic          w_rise;
  logic          w_fall;
  logic          w_tick;
  logic          w_clear;
  logic          w_click;
  logic          w_dclick;
  logic          w_long;

  assign w_rise = i_btn & ~r_btn_q;
  assign w_fall = ~i_btn & r_btn_q;
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

`ifdef BUTTON_REPEAT_EN
  logic r_repeat;
  logic w_repeat;
`endif

  // Next-state and event decode; edges are tested before tick expiry so an
  // edge landing on the expiry tick wins and suppresses the timeout pulse.
  always_comb begin
    w_next   = r_state;
    w_click  = 1'b0;
    w_dclick = 1'b0;
    w_long   = 1'b0;
`ifdef BUTTON_REPEAT_EN
    w_repeat = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_rise) w_next = PRESS1;
      end
      PRESS1: begin
        if (w_fall) begin
          w_next = WAIT2;
        end else if (w_tick && (r_timer == TW'(LONG_T - 1))) begin
          w_next = LONG;
          w_long = 1'b1;
        end
      end
      WAIT2: begin
        if (w_rise) begin
          w_next = PRESS2;
        end else if (w_tick && (r_timer == TW'(DCLICK_T - 1))) begin
          w_next  = IDLE;
          w_click = 1'b1;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_next   = IDLE;
          w_dclick = 1'b1;
        end
      end
      LONG: begin
        if (w_fall) begin
          w_next = IDLE;
`ifdef BUTTON_REPEAT_EN
        end else if (w_tick && (r_timer == TW'(REPEAT_T - 1))) begin
          w_repeat = 1'b1;
`endif
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef BUTTON_REPEAT_EN
  // A repeat pulse restarts the interval without leaving LONG.
  assign w_clear = (w_next != r_state) | w_repeat;
`else
  assign w_clear = (w_next != r_state);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_btn_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_btn_q <= i_btn;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (w_clear) begin
      r_presc <= '0;
      r_timer <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_timer != '1) r_timer <= r_timer + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_click  <= 1'b0;
      r_dclick <= 1'b0;
      r_long   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_click  <= w_click;
      r_dclick <= w_dclick;
      r_long   <= w_long;
      r_busy   <= (w_next != IDLE);
    end
  end

`ifdef BUTTON_REPEAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_repeat <= 1'b0;
    else          r_repeat <= w_repeat;
  end
  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_click      = r_click;
  assign o_dclick     = r_dclick;
  assign o_long_press = r_long;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//   Directed, table-driven bench for button_event with TICK_DIV=4, LONG_T=10,
//   DCLICK_T=5, REPEAT_T=3. Each vector describes a press/gap/press pattern and
//   the expected count and first edge index of every output pulse, where edge 0
//   is the first clock edge at which the button is sampled high.
// -----------------------------------------------------------------------------
module tb_button_event;

  logic clk;
  logic rst_n;
  logic btn;
  logic click;
  logic dclick;
  logic long_press;
  logic rpt;
  logic busy;

  int checks   = 0;
  int failures = 0;

`ifdef BUTTON_REPEAT_EN
  localparam bit REN = 1'b1;
`else
  localparam bit REN = 1'b0;
`endif

  button_event #(
    .TICK_DIV(4),
    .LONG_T  (10),
    .DCLICK_T(5),
    .REPEAT_T(3)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn       (btn),
    .o_click     (click),
    .o_dclick    (dclick),
    .o_long_press(long_press),
    .o_repeat    (rpt),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int h1;
    int lo;
    int h2;
    int n_click;
    int t_click;
    int n_dclick;
    int t_dclick;
    int n_long;
    int t_long;
    int n_rep;
    int t_rep;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    int nc, nd, nl, nr, tc, td, tl, tr, multi;
    bit b;

    //           h1  lo  h2 nclk tclk ndcl tdcl nlng tlng  nrep  trep
    vecs[0] = '{12,  0,  0,  1,  32,   0,  -1,  0,  -1,   0,   -1};
    vecs[1] = '{ 8,  8,  8,  0,  -1,   1,  24,  0,  -1,   0,   -1};
    vecs[2] = '{70,  0,  0,  0,  -1,   0,  -1,  1,  40, REN ? 2 : 0, REN ? 52 : -1};
    vecs[3] = '{40,  0,  0,  1,  60,   0,  -1,  0,  -1,   0,   -1};
    vecs[4] = '{39,  0,  0,  1,  59,   0,  -1,  0,  -1,   0,   -1};
    vecs[5] = '{41,  0,  0,  0,  -1,   0,  -1,  1,  40,   0,   -1};
    vecs[6] = '{ 4, 20,  4,  0,  -1,   1,  28,  0,  -1,   0,   -1};
    vecs[7] = '{ 4, 21,  4,  2,  24,   0,  -1,  0,  -1,   0,   -1};

    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {click, dclick, long_press, rpt, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    for (int v = 0; v < 8; v++) begin
      nc = 0; nd = 0; nl = 0; nr = 0;
      tc = -1; td = -1; tl = -1; tr = -1;
      multi = 0;
      for (int k = 0; k < 80; k++) begin
        b = (k < vecs[v].h1) ||
            ((k >= vecs[v].h1 + vecs[v].lo) && (k < vecs[v].h1 + vecs[v].lo + vecs[v].h2));
        btn = b;
        @(posedge clk);
        #1;
        if (click)      begin nc++; if (tc < 0) tc = k; end
        if (dclick)     begin nd++; if (td < 0) td = k; end
        if (long_press) begin nl++; if (tl < 0) tl = k; end
        if (rpt)        begin nr++; if (tr < 0) tr = k; end
        if (int'(click) + int'(dclick) + int'(long_press) + int'(rpt) > 1) multi++;
      end
      check($sformatf("v%0d_n_click", v),  nc, vecs[v].n_click);
      check($sformatf("v%0d_t_click", v),  tc, vecs[v].t_click);
      check($sformatf("v%0d_n_dclick", v), nd, vecs[v].n_dclick);
      check($sformatf("v%0d_t_dclick", v), td, vecs[v].t_dclick);
      check($sformatf("v%0d_n_long", v),   nl, vecs[v].n_long);
      check($sformatf("v%0d_t_long", v),   tl, vecs[v].t_long);
      check($sformatf("v%0d_n_repeat", v), nr, vecs[v].n_rep);
      check($sformatf("v%0d_t_repeat", v), tr, vecs[v].t_rep);
      check($sformatf("v%0d_onehot", v),   multi, 0);
      check($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // Short press, then asynchronous reset while waiting for a second press.
    btn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    btn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("wait2_busy_before_reset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_outputs", {click, dclick, long_press, rpt}, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    nc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (click || dclick || long_press || rpt) nc++;
    end
    check("no_pulse_after_reset", nc, 0);
    check("idle_after_reset", busy, 0);

    // Button held high through reset release counts as a fresh press.
    rst_n = 1'b0;
    btn   = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("held_through_reset_rise", busy, 1);
    btn = 1'b0;
    nc = 0;
    tc = -1;
    for (int k = 1; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (click) begin nc++; if (tc < 0) tc = k; end
    end
    check("held_through_reset_click_n", nc, 1);
    check("held_through_reset_click_t", tc, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1500: clk cycles per timing tick, >=2.
REQ-002 SHALL have parameter LONG_T, default 800: ticks held before a long press is reported, >=1.
REQ-003 SHALL have parameter DCLICK_T, default 250: ticks after a release during which a second press counts as a double click, >=1.
REQ-004 SHALL have parameter REPEAT_T, default 100: ticks between auto-repeat pulses, >=1.
REQ-005 SHALL have port clk  input  1  system clock; all logic is on posedge clk.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port btn  input  1  debounced, clk-synchronous button level (Debouncer LEVEL output); 1 means pressed.
REQ-008 SHALL have port click  output  1  one-cycle pulse: single short press confirmed.
REQ-009 SHALL have port dclick  output  1  one-cycle pulse: double click.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse: hold reached LONG_T.
REQ-011 SHALL have port repeat  output  1  one-cycle auto-repeat pulse while held long.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL register btn into btn_q every cycle; rise = btn & ~btn_q, fall = ~btn & btn_q.
REQ-014 SHALL clear the prescaler (0..TICK_DIV-1) and the tick timer to 0 on every state transition; tick = (prescaler == TICK_DIV-1); timer increments on tick and saturates at its maximum.
REQ-015 SHALL size the timer as $clog2(max(LONG_T,DCLICK_T,REPEAT_T)+1) bits.
REQ-016 SHALL implement states IDLE, PRESS1, WAIT2, PRESS2, LONG.
REQ-017 IDLE: rise -> PRESS1.
REQ-018 PRESS1: fall -> WAIT2; else tick with timer == LONG_T-1 -> LONG, long_press pulse.
REQ-019 WAIT2: rise -> PRESS2; else tick with timer == DCLICK_T-1 -> IDLE, click pulse.
REQ-020 PRESS2: fall -> IDLE, dclick pulse; no long-press detection in PRESS2.
REQ-021 LONG: fall -> IDLE with no pulse; repeat behaviour per REQ-027/028.
REQ-022 SHALL give an edge priority over a same-cycle tick expiry (the edge transition is taken, no timeout pulse).
REQ-023 SHALL drive all outputs from registers; each pulse is high exactly one cycle, on the cycle after the clock edge that takes the transition.
REQ-024 SHALL assert long_press exactly LONG_T*TICK_DIV cycles after the edge entering PRESS1, and click exactly DCLICK_T*TICK_DIV cycles after the edge entering WAIT2.
REQ-025 SHALL never assert more than one of click/dclick/long_press/repeat in the same cycle.

Reset
REQ-026 SHALL, on rst_n low (asynchronous, mid-operation included), force state IDLE, btn_q, prescaler, timer and all outputs to 0 with no pulse emitted; a btn held high through reset release is treated as a rise on the first clock after release.

Configuration
REQ-027 With BUTTON_REPEAT_EN defined, the block SHALL, in LONG, pulse repeat on every tick where timer == REPEAT_T-1, then clear timer and prescaler, continuing until fall.
REQ-028 Without BUTTON_REPEAT_EN, the block SHALL tie repeat to 0, and LONG SHALL only wait for fall; the repeat counter logic is not synthesized.

Verification (TICK_DIV=4, LONG_T=10, DCLICK_T=5, REPEAT_T=3)
REQ-029 btn high 12 cycles then low -> single click pulse 20 cycles after the edge entering WAIT2; busy low the next cycle.
REQ-030 btn high 8, low 8, high 8, low -> dclick pulse one cycle after the second fall edge is processed; no click pulse.
REQ-031 btn high 70 cycles, BUTTON_REPEAT_EN defined -> long_press 40 cycles after press entry, repeat at +12, +24 cycles thereafter; no pulse on release.
REQ-032 Same stimulus without BUTTON_REPEAT_EN -> long_press only, repeat constantly 0.
REQ-033 btn fall on the same cycle as the LONG_T-1 tick -> WAIT2 taken, no long_press.
REQ-034 rst_n pulsed low while in WAIT2 -> all outputs 0, no click ever emitted; busy low immediately.
